// File: rtl/toggle_handshake_rx.sv
// Receiver for a two-phase toggle handshake: synchronizes req_t, captures data_in,
// presents it on a valid/ready stream and answers by toggling ack_t.
module toggle_handshake_rx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_t,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_t,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              overrun,
  output logic [CNT_W-1:0]  xfer_count
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   req_seen_q, req_seen_d;
  logic                   pending;

  logic                   ack_d;
  logic [DATA_W-1:0]      dout_d;
  logic                   valid_d;
  logic                   overrun_d;
  logic [CNT_W-1:0]       count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_t};
    end
  end

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign pending = (req_s != req_seen_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_seen_q <= 1'b0;
      ack_t      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      xfer_count <= '0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      ack_t      <= ack_d;
      dout       <= dout_d;
      dout_valid <= valid_d;
      overrun    <= overrun_d;
      xfer_count <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    ack_d      = ack_t;
    dout_d     = dout;
    valid_d    = dout_valid;
    overrun_d  = overrun;
    count_d    = xfer_count;
    case (state_q)
      IDLE: begin
        if (pending) begin
          dout_d     = data_in;
          req_seen_d = req_s;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // An early toggle stays pending (req_seen untouched) and is serviced from IDLE later.
        if (pending) begin
          overrun_d = 1'b1;
        end
        if (dout_ready) begin
          valid_d = 1'b0;
          ack_d   = ~ack_t;
          count_d = xfer_count + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
